// File: rtl/alu_32.sv
// Registered 32-bit ALU: the result and the N/Z/C/V flags for one opcode are
// computed combinationally and loaded into the output registers on every rising edge.
module alu_32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  opCode,
    output logic [31:0] out,
    output logic [3:0]  S
);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_NOR   = 5'd5;
    localparam logic [4:0] OP_SLL   = 5'd6;
    localparam logic [4:0] OP_SRL   = 5'd7;
    localparam logic [4:0] OP_SRA   = 5'd8;
    localparam logic [4:0] OP_SLT   = 5'd9;
    localparam logic [4:0] OP_SLTU  = 5'd10;
    localparam logic [4:0] OP_PASSA = 5'd11;
    localparam logic [4:0] OP_PASSB = 5'd12;

    logic [32:0] add_sum;
    logic [32:0] sub_sum;
    logic [4:0]  shamt;
    logic [31:0] result_next;
    logic        carry_next;
    logic        ovf_next;
    logic [3:0]  flags_next;

    // Subtraction goes through the adder form a + ~b + 1 so bit 32 is the
    // no-borrow carry that the condition logic expects.
    assign add_sum = {1'b0, a} + {1'b0, b};
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
    assign shamt   = b[4:0];

    always_comb begin
        result_next = '0;
        carry_next  = 1'b0;
        ovf_next    = 1'b0;
        case (opCode)
            OP_ADD: begin
                result_next = add_sum[31:0];
                carry_next  = add_sum[32];
                ovf_next    = (a[31] == b[31]) && (add_sum[31] != a[31]);
            end
            OP_SUB: begin
                result_next = sub_sum[31:0];
                carry_next  = sub_sum[32];
                ovf_next    = (a[31] != b[31]) && (sub_sum[31] != a[31]);
            end
            OP_AND:   result_next = a & b;
            OP_OR:    result_next = a | b;
            OP_XOR:   result_next = a ^ b;
            OP_NOR:   result_next = ~(a | b);
            OP_SLL:   result_next = a << shamt;
            OP_SRL:   result_next = a >> shamt;
            OP_SRA:   result_next = $unsigned($signed(a) >>> shamt);
            OP_SLT:   result_next = {31'd0, ($signed(a) < $signed(b))};
            OP_SLTU:  result_next = {31'd0, (a < b)};
            OP_PASSA: result_next = a;
            OP_PASSB: result_next = b;
            default:  result_next = '0;
        endcase
    end

    assign flags_next = {result_next[31], (result_next == 32'd0), carry_next, ovf_next};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
            S   <= '0;
        end else begin
            out <= result_next;
            S   <= flags_next;
        end
    end

endmodule

// File: tb/tb_alu_32.sv
// Bench for alu_32: directed vector table, reset/timing sequences, and random
// operations checked against an arithmetic reference model.
module tb_alu_32;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  opCode;
    logic [31:0] out;
    logic [3:0]  S;

    int tests_run = 0;
    int tests_failed = 0;

    alu_32 dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .b(b),
        .opCode(opCode),
        .out(out),
        .S(S)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] exp_out;
        logic [3:0]  exp_s;
    } vec_t;

    vec_t vecs[$];

    // Reference built from integer arithmetic on wide signed/unsigned values.
    function automatic logic [35:0] ref_model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        longint unsigned ux = x;
        longint unsigned uy = y;
        int              ix = x;
        int              iy = y;
        longint          sx = ix;
        longint          sy = iy;
        longint unsigned uw;
        longint          sw;
        int              sh = int'(y[4:0]);
        logic [31:0]     r = '0;
        logic            c = 1'b0;
        logic            v = 1'b0;
        case (op)
            5'd0: begin
                uw = ux + uy;
                r  = uw[31:0];
                c  = (uw >= 64'h1_0000_0000);
                sw = sx + sy;
                v  = (sw > 64'sd2147483647) || (sw < -64'sd2147483648);
            end
            5'd1: begin
                r  = x - y;
                c  = (ux >= uy);
                sw = sx - sy;
                v  = (sw > 64'sd2147483647) || (sw < -64'sd2147483648);
            end
            5'd2:  r = x & y;
            5'd3:  r = x | y;
            5'd4:  r = x ^ y;
            5'd5:  r = ~(x | y);
            5'd6:  r = x << sh;
            5'd7:  r = x >> sh;
            5'd8:  r = ix >>> sh;
            5'd9:  r = (ix < iy) ? 32'd1 : 32'd0;
            5'd10: r = (ux < uy) ? 32'd1 : 32'd0;
            5'd11: r = x;
            5'd12: r = y;
            default: r = '0;
        endcase
        return {r, r[31], (r == 32'd0), c, v};
    endfunction

    task automatic check(input string name, input logic [31:0] exp_out, input logic [3:0] exp_s);
        tests_run++;
        if (out !== exp_out || S !== exp_s) begin
            tests_failed++;
            $display("[TB] FAIL %s: out=%08h S=%04b, required out=%08h S=%04b",
                     name, out, S, exp_out, exp_s);
        end else begin
            $display("[TB] ok   %s: op=%0d a=%08h b=%08h out=%08h S=%04b",
                     name, opCode, a, b, out, S);
        end
    endtask

    task automatic apply(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        opCode = op;
        a      = x;
        b      = y;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] edges[6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0000001F};

    initial begin
        logic [35:0] m;
        logic [4:0]  rop;
        logic [31:0] ra, rb;

        vecs.push_back('{"add7_2",  5'd0, 32'd7, 32'd2, 32'd9,          4'b0000});
        vecs.push_back('{"sub7_2",  5'd1, 32'd7, 32'd2, 32'd5,          4'b0010});
        vecs.push_back('{"and7_2",  5'd2, 32'd7, 32'd2, 32'd2,          4'b0000});
        vecs.push_back('{"or7_2",   5'd3, 32'd7, 32'd2, 32'd7,          4'b0000});
        vecs.push_back('{"xor7_2",  5'd4, 32'd7, 32'd2, 32'd5,          4'b0000});
        vecs.push_back('{"nor7_2",  5'd5, 32'd7, 32'd2, 32'hFFFFFFF8,   4'b1000});
        vecs.push_back('{"sll7_2",  5'd6, 32'd7, 32'd2, 32'h1C,         4'b0000});
        vecs.push_back('{"srl7_2",  5'd7, 32'd7, 32'd2, 32'd1,          4'b0000});
        vecs.push_back('{"sra7_2",  5'd8, 32'd7, 32'd2, 32'd1,          4'b0000});
        vecs.push_back('{"add_ff",  5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1010});
        vecs.push_back('{"add_ovf", 5'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'b1001});
        vecs.push_back('{"add_00",  5'd0, 32'd0, 32'd0, 32'd0,          4'b0100});
        vecs.push_back('{"add_neg", 5'd0, 32'h80000004, 32'd1, 32'h80000005, 4'b1000});
        vecs.push_back('{"sra_31",  5'd8, 32'h80000000, 32'd31, 32'hFFFFFFFF, 4'b1000});
        vecs.push_back('{"slt_m1",  5'd9, 32'hFFFFFFFF, 32'd1, 32'd1,   4'b0000});
        vecs.push_back('{"sltu_m1", 5'd10, 32'hFFFFFFFF, 32'd1, 32'd0,  4'b0100});
        vecs.push_back('{"op20",    5'd20, 32'h12345678, 32'h9ABCDEF0, 32'd0, 4'b0100});
        vecs.push_back('{"passa",   5'd11, 32'hDEADBEEF, 32'd3, 32'hDEADBEEF, 4'b1000});
        vecs.push_back('{"passb",   5'd12, 32'hDEADBEEF, 32'd3, 32'd3,  4'b0000});

        rst = 1'b1;
        a = 32'h0; b = 32'h0; opCode = 5'd0;
        a = 32'd5; b = 32'd6;
        @(posedge clk);
        #1;
        check("rst_held", 32'd0, 4'b0000);

        @(negedge clk);
        rst = 1'b0;
        apply(5'd0, 32'd5, 32'd6);
        check("first_load", 32'd11, 4'b0000);

        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].va, vecs[i].vb);
            check(vecs[i].name, vecs[i].exp_out, vecs[i].exp_s);
        end

        // Mid-cycle input changes must not reach the outputs before the next edge.
        apply(5'd11, 32'hCAFEF00D, 32'd0);
        #2;
        a = 32'h1; opCode = 5'd12;
        #1;
        check("hold_between_edges", 32'hCAFEF00D, 4'b1000);

        // Asynchronous reset clears the outputs with no clock edge.
        #1;
        rst = 1'b1;
        #1;
        check("async_rst", 32'd0, 4'b0000);
        @(posedge clk);
        #1;
        check("rst_held2", 32'd0, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        apply(5'd1, 32'd2, 32'd7);
        check("after_rst_sub", 32'hFFFFFFFB, 4'b1000);

        for (int i = 0; i < 200; i++) begin
            rop = 5'($urandom_range(0, 31));
            ra  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            m   = ref_model(rop, ra, rb);
            apply(rop, ra, rb);
            check($sformatf("rand%0d", i), m[35:4], m[3:0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
